prio_enc_8x3_seq: RTL and testbench
===================================

Name: prio_enc_8x3_seq

Overview:
Registered 8-to-3 priority encoder with request capture and a valid/ack handshake. It performs the inverse of the 3x8 decoder. Eight request lines are edge-captured into a pending register. The highest-index pending request is presented as a 3-bit code with valid, and a consumer ack retires that request. The block serves as the request/interrupt front-end feeding logic that selects one of eight sources.

Parameters:
WIDTH, 8, number of request lines (fixed at 8 for this revision)
CODE_W, 3, code width, equal to clog2(WIDTH)

Ports:
clk    input   1       system clock, rising edge
rst    input   1       asynchronous, active-high reset
en_n   input   1       active-low enable; 0 = encoder may present new codes
req    input   8       request lines, bit i = source i, level signals
ack    input   1       consumer accepts the presented code; sampled only while valid=1
code   output  3       index of highest-priority presented request (7 highest, 0 lowest)
valid  output  1       code is valid and stable
pend   output  8       current pending register (status/debug)
ovf    output  1       one-cycle pulse: new rising edge on a bit already pending

Behaviour:
- Reset (async, rst=1): code=0, valid=0, pend=0, ovf=0, req_q=0, state=S_IDLE.
  - Because req_q resets to 0, a req bit held high through reset release counts as a rising edge on the first clock.
- Edge capture: rise = req & ~req_q; req_q <= req every clock.
  - pend_next = (pend & ~clr) | rise.
  - Set wins over clear on the same bit in the same cycle.
- ovf <= |(rise & pend), registered, one cycle.
- Priority rule: highest set index of pend wins. A combinational encoder produces enc_code and any = |pend.
- FSM, state S_IDLE:
  - If en_n=0 and any=1: code <= enc_code, valid <= 1, go to S_PRESENT.
  - Otherwise hold, with valid=0.
- FSM, state S_PRESENT:
  - code and valid are held stable regardless of new higher-priority requests. There is no preemption.
  - On ack=1: clr = one-hot(code), valid <= 0, go to S_IDLE.
- Latency:
  - req rises before edge k -> pend bit set after edge k -> valid=1 after edge k+1.
  - After an ack at edge m, the next valid rises at edge m+1 at the earliest, so valid is low for one cycle between presentations.
- en_n=1:
  - In S_IDLE, blocks presentation.
  - In S_PRESENT, does not abort the current code; ack is still honoured.
  - Capture into pend continues in both states.
- ack while valid=0: ignored, no effect.
- All eight bits set: presented order is 7,6,...,0 on successive acks, assuming no new edges arrive.
- Reset mid-presentation: everything clears immediately; no ack is required.

Optional Feature:
LEVEL_MODE_EN
- Defined:
  - pend <= req every cycle (level-sensitive); edge detect and clr are unused.
  - ovf is tied to 0.
  - ack only returns the FSM to S_IDLE.
  - A source still high after ack is re-presented.
- Undefined: edge-capture behaviour exactly as specified above.

Decomposition:
- Package prio_enc_pkg holds:
  - the constants WIDTH=8 and CODE_W=3
  - typedef enum state_t {S_IDLE, S_PRESENT}
  - function onehot(code), returning an 8-bit mask
- Sub-module prio_enc_8x3: purely combinational; inputs pend[7:0]; outputs enc_code[2:0] and any. The top instantiates it once.

Test Plan:
1. Reset, then req=8'b0000_0010 pulsed for 1 cycle, en_n=0 -> pend=02 after edge 1, then valid=1 and code=1 after edge 2; ack=1 -> valid=0, pend=00.
2. Rising edges on req=8'b1001_0001 in one cycle, ack held 1 -> codes presented 7, 4, 0 with a one-cycle valid gap between each; pend ends at 00.
3. While code=2 is presented, raise req[6] -> code stays 2 until ack; next presentation is code=6.
4. en_n=1 with req[3] rising -> pend=08, valid stays 0. Drop en_n to 0 -> valid=1 and code=3 one cycle later.
5. With bit 5 pending, drop then re-raise req[5] -> ovf pulses 1 for exactly one cycle and pend[5] stays 1. If the re-raise lands in the ack cycle for code 5 -> pend[5] remains 1 and code 5 is re-presented.
6. Assert rst asynchronously mid-cycle while valid=1, code=4 -> valid, code, and pend go to 0 immediately without waiting for a clock edge. With LEVEL_MODE_EN, req[4] held high -> code 4 is re-presented after each ack.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 8-to-3 priority encoder.
package prio_enc_pkg;

    localparam int WIDTH  = 8;
    localparam int CODE_W = 3;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    function automatic logic [WIDTH-1:0] onehot(input logic [CODE_W-1:0] code);
        logic [WIDTH-1:0] one;
        one    = 8'd1;
        onehot = one << code;
    endfunction

endpackage

// File: rtl/prio_enc_8x3.sv
// Combinational 8-to-3 priority encoder: highest set bit of pend wins.
module prio_enc_8x3
    import prio_enc_pkg::*;
(
    input  logic [WIDTH-1:0]  pend,
    output logic [CODE_W-1:0] enc_code,
    output logic              any
);

    // Highest-index set bit selects the code
    always_comb begin
        any = |pend;
        casez (pend)
            8'b1???????: enc_code = 3'd7;
            8'b01??????: enc_code = 3'd6;
            8'b001?????: enc_code = 3'd5;
            8'b0001????: enc_code = 3'd4;
            8'b00001???: enc_code = 3'd3;
            8'b000001??: enc_code = 3'd2;
            8'b0000001?: enc_code = 3'd1;
            8'b00000001: enc_code = 3'd0;
            default:     enc_code = 3'd0;
        endcase
    end

endmodule

// File: rtl/prio_enc_8x3_seq.sv
// Registered 8-to-3 priority encoder with edge-captured requests and valid/ack handshake.
// Optional build macro LEVEL_MODE_EN: pend follows req directly, ovf tied low.
module prio_enc_8x3_seq
    import prio_enc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en_n,
    input  logic [WIDTH-1:0]  req,
    input  logic              ack,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic [WIDTH-1:0]  pend,
    output logic              ovf
);

    logic [WIDTH-1:0]  req_q_r;
    logic [WIDTH-1:0]  pend_r;
    logic [WIDTH-1:0]  rise_s;
    logic [WIDTH-1:0]  clr_s;
    logic [WIDTH-1:0]  pend_next_s;
    logic              ovf_next_s;
    logic              ovf_r;
    logic [CODE_W-1:0] code_r;
    logic              valid_r;
    logic [CODE_W-1:0] enc_code_s;
    logic              any_s;
    state_t            state_r;

    prio_enc_8x3 u_enc (
        .pend     (pend_r),
        .enc_code (enc_code_s),
        .any      (any_s)
    );

    // Next pending mask: retire the acked code, new rising edges win over the clear
    always_comb begin
        rise_s = req & ~req_q_r;
        if ((state_r == S_PRESENT) && ack) begin
            clr_s = onehot(code_r);
        end else begin
            clr_s = 8'h00;
        end
`ifdef LEVEL_MODE_EN
        pend_next_s = req;
        ovf_next_s  = 1'b0;
`else
        pend_next_s = (pend_r & ~clr_s) | rise_s;
        ovf_next_s  = |(rise_s & pend_r);
`endif
    end

    // Request history, pending register and overflow pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q_r <= 8'h00;
            pend_r  <= 8'h00;
            ovf_r   <= 1'b0;
        end else begin
            req_q_r <= req;
            pend_r  <= pend_next_s;
            ovf_r   <= ovf_next_s;
        end
    end

    // Presentation FSM; code is frozen while presented (no preemption)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            code_r  <= 3'd0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (!en_n && any_s) begin
                        code_r  <= enc_code_s;
                        valid_r <= 1'b1;
                        state_r <= S_PRESENT;
                    end else begin
                        valid_r <= 1'b0;
                    end
                end
                S_PRESENT: begin
                    if (ack) begin
                        valid_r <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    code_r  <= 3'd0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign code  = code_r;
    assign valid = valid_r;
    assign pend  = pend_r;
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_prio_enc_8x3_seq.sv
// Directed self-checking bench for prio_enc_8x3_seq; inputs driven and outputs sampled 1ns after rising edges.
module tb_prio_enc_8x3_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       ack = 1'b0;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pend;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;

    prio_enc_8x3_seq dut (
        .clk   (clk),
        .rst   (rst),
        .en_n  (en_n),
        .req   (req),
        .ack   (ack),
        .code  (code),
        .valid (valid),
        .pend  (pend),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if ({valid, code, pend, ovf} !== 13'd0) begin n_fail++; $display("FAIL reset_outputs: got v=%b c=%0d p=%h o=%b expected all 0", valid, code, pend, ovf); end
        cyc();
        rst = 1'b0;
        cyc();
        n_checks++; if ({valid, pend, ovf} !== 10'd0) begin n_fail++; $display("FAIL reset_idle: got v=%b p=%h o=%b expected 0", valid, pend, ovf); end
    endtask

    task automatic test_single();
        req = 8'h02;
        cyc();
        n_checks++; if (pend !== 8'h02 || valid !== 1'b0) begin n_fail++; $display("FAIL single_capture: got p=%h v=%b expected p=02 v=0", pend, valid); end
        req = 8'h00;
        cyc();
        n_checks++; if (valid !== 1'b1 || code !== 3'd1) begin n_fail++; $display("FAIL single_present: got v=%b c=%0d expected v=1 c=1", valid, code); end
        ack = 1'b1;
        cyc();
        n_checks++; if (valid !== 1'b0 || pend !== 8'h00) begin n_fail++; $display("FAIL single_ack: got v=%b p=%h expected v=0 p=00", valid, pend); end
        ack = 1'b0;
    endtask

    task automatic test_multi_order();
        logic [2:0] exp_codes [3];
        exp_codes[0] = 3'd7; exp_codes[1] = 3'd4; exp_codes[2] = 3'd0;
        req = 8'h91;
        cyc();
        n_checks++; if (pend !== 8'h91) begin n_fail++; $display("FAIL multi_capture: got p=%h expected 91", pend); end
        req = 8'h00;
        ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++; if (valid !== 1'b1 || code !== exp_codes[i]) begin n_fail++; $display("FAIL multi_code%0d: got v=%b c=%0d expected v=1 c=%0d", i, valid, code, exp_codes[i]); end
            cyc();
            n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL multi_gap%0d: got v=%b expected 0", i, valid); end
        end
        n_checks++; if (pend !== 8'h00) begin n_fail++; $display("FAIL multi_final_pend: got %h expected 00", pend); end
        cyc();
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL multi_idle: got v=%b expected 0", valid); end
        ack = 1'b0;
    endtask

    task automatic test_no_preempt();
        req = 8'h04;
        cyc();
        req = 8'h00;
        cyc();
        n_checks++; if (valid !== 1'b1 || code !== 3'd2) begin n_fail++; $display("FAIL nopre_present: got v=%b c=%0d expected v=1 c=2", valid, code); end
        req = 8'h40;
        cyc();
        n_checks++; if (code !== 3'd2 || pend !== 8'h44) begin n_fail++; $display("FAIL nopre_hold: got c=%0d p=%h expected c=2 p=44", code, pend); end
        req = 8'h00;
        cyc();
        n_checks++; if (valid !== 1'b1 || code !== 3'd2) begin n_fail++; $display("FAIL nopre_hold2: got v=%b c=%0d expected v=1 c=2", valid, code); end
        ack = 1'b1;
        cyc();
        n_checks++; if (valid !== 1'b0 || pend !== 8'h40) begin n_fail++; $display("FAIL nopre_ack: got v=%b p=%h expected v=0 p=40", valid, pend); end
        ack = 1'b0;
        cyc();
        n_checks++; if (valid !== 1'b1 || code !== 3'd6) begin n_fail++; $display("FAIL nopre_next: got v=%b c=%0d expected v=1 c=6", valid, code); end
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        n_checks++; if (pend !== 8'h00) begin n_fail++; $display("FAIL nopre_clear: got p=%h expected 00", pend); end
    endtask

    task automatic test_enable();
        en_n = 1'b1;
        req  = 8'h08;
        cyc();
        n_checks++; if (pend !== 8'h08 || valid !== 1'b0) begin n_fail++; $display("FAIL en_capture: got p=%h v=%b expected p=08 v=0", pend, valid); end
        req = 8'h00;
        cyc();
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL en_block: got v=%b expected 0", valid); end
        en_n = 1'b0;
        cyc();
        n_checks++; if (valid !== 1'b1 || code !== 3'd3) begin n_fail++; $display("FAIL en_present: got v=%b c=%0d expected v=1 c=3", valid, code); end
        en_n = 1'b1;
        cyc();
        n_checks++; if (valid !== 1'b1 || code !== 3'd3) begin n_fail++; $display("FAIL en_no_abort: got v=%b c=%0d expected v=1 c=3", valid, code); end
        ack = 1'b1;
        cyc();
        n_checks++; if (valid !== 1'b0 || pend !== 8'h00) begin n_fail++; $display("FAIL en_ack: got v=%b p=%h expected v=0 p=00", valid, pend); end
        ack  = 1'b0;
        en_n = 1'b0;
        cyc();
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ack_idle_ignored: got v=%b expected 0", valid); end
    endtask

    task automatic test_overflow();
        req = 8'h20;
        cyc();
        req = 8'h00;
        cyc();
        n_checks++; if (valid !== 1'b1 || code !== 3'd5 || ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_present: got v=%b c=%0d o=%b expected v=1 c=5 o=0", valid, code, ovf); end
        req = 8'h20;
        cyc();
        n_checks++; if (ovf !== 1'b1 || pend !== 8'h20) begin n_fail++; $display("FAIL ovf_pulse: got o=%b p=%h expected o=1 p=20", ovf, pend); end
        req = 8'h00;
        cyc();
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle: got o=%b expected 0", ovf); end
        req = 8'h20;
        ack = 1'b1;
        cyc();
        n_checks++; if (pend !== 8'h20 || valid !== 1'b0 || ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got p=%h v=%b o=%b expected p=20 v=0 o=1", pend, valid, ovf); end
        req = 8'h00;
        ack = 1'b0;
        cyc();
        n_checks++; if (valid !== 1'b1 || code !== 3'd5) begin n_fail++; $display("FAIL ovf_represent: got v=%b c=%0d expected v=1 c=5", valid, code); end
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        n_checks++; if (pend !== 8'h00) begin n_fail++; $display("FAIL ovf_clear: got p=%h expected 00", pend); end
    endtask

    task automatic test_async_reset();
        req = 8'h10;
        cyc();
        req = 8'h00;
        cyc();
        n_checks++; if (valid !== 1'b1 || code !== 3'd4) begin n_fail++; $display("FAIL arst_present: got v=%b c=%0d expected v=1 c=4", valid, code); end
        #3;
        rst = 1'b1;
        #1;
        n_checks++; if ({valid, code, pend} !== 12'd0) begin n_fail++; $display("FAIL arst_immediate: got v=%b c=%0d p=%h expected all 0", valid, code, pend); end
        req = 8'h10;
        cyc();
        rst = 1'b0;
        cyc();
        n_checks++; if (pend !== 8'h10 || valid !== 1'b0) begin n_fail++; $display("FAIL arst_held_req_edge: got p=%h v=%b expected p=10 v=0", pend, valid); end
        cyc();
        n_checks++; if (valid !== 1'b1 || code !== 3'd4) begin n_fail++; $display("FAIL arst_after: got v=%b c=%0d expected v=1 c=4", valid, code); end
        req = 8'h00;
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        n_checks++; if (valid !== 1'b0 || pend !== 8'h00) begin n_fail++; $display("FAIL arst_final: got v=%b p=%h expected v=0 p=00", valid, pend); end
    endtask

    task automatic test_level_mode();
        req = 8'h10;
        cyc();
        n_checks++; if (pend !== 8'h10) begin n_fail++; $display("FAIL lvl_pend: got p=%h expected 10", pend); end
        cyc();
        n_checks++; if (valid !== 1'b1 || code !== 3'd4) begin n_fail++; $display("FAIL lvl_present: got v=%b c=%0d expected v=1 c=4", valid, code); end
        ack = 1'b1;
        cyc();
        n_checks++; if (valid !== 1'b0 || pend !== 8'h10 || ovf !== 1'b0) begin n_fail++; $display("FAIL lvl_ack: got v=%b p=%h o=%b expected v=0 p=10 o=0", valid, pend, ovf); end
        ack = 1'b0;
        cyc();
        n_checks++; if (valid !== 1'b1 || code !== 3'd4) begin n_fail++; $display("FAIL lvl_represent: got v=%b c=%0d expected v=1 c=4", valid, code); end
        req = 8'h00;
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        cyc();
        n_checks++; if (valid !== 1'b0 || pend !== 8'h00) begin n_fail++; $display("FAIL lvl_release: got v=%b p=%h expected v=0 p=00", valid, pend); end
    endtask

    initial begin
        test_reset();
`ifdef LEVEL_MODE_EN
        test_level_mode();
`else
        test_single();
        test_multi_order();
        test_no_preempt();
        test_enable();
        test_overflow();
        test_async_reset();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
